// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, the ebreak
// encoding, the default reset PC and the fetch FSM state type.
package inst_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] EBREAK           = 32'h0010_0073;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_STOP  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer holding {pc, inst} fetch entries; flush empties it in one edge.
// Pointers wrap modulo DEPTH, so non-power-of-two depths are handled as well.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: dout is masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign count = r_count;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, FETCH/STOP/HALT control and redirect handling
// in front of a small fetch buffer feeding decode.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] rom_addr,
  input  logic [XLEN-1:0] rom_inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic            halt
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [XLEN-1:0]     r_pc;
  logic [XLEN-1:0]     w_pc_nxt;
  logic                w_push;
  logic                w_flush;
  logic                w_pop;
  logic                w_pop_ebreak;
  logic                w_can_push;
  logic [CW-1:0]       w_count;
  logic [2*XLEN-1:0]   w_head;

  assign w_pop        = out_valid & out_ready;
  assign w_pop_ebreak = w_pop & (w_head[XLEN-1:0] == EBREAK);
  assign w_can_push   = (w_count < CW'(FIFO_DEPTH)) | w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Priority: consuming an ebreak > redirect > normal fetch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      S_HALT: ;
      default: begin
        if (w_pop_ebreak) begin
          w_state_nxt = S_HALT;
        end else if (redirect_valid) begin
          w_flush     = 1'b1;
          w_pc_nxt    = redirect_pc & ~32'h3;
          w_state_nxt = S_FETCH;
        end else if (r_state == S_FETCH && w_can_push) begin
          w_push   = 1'b1;
          w_pc_nxt = r_pc + 32'd4;
          if (rom_inst == EBREAK) w_state_nxt = S_STOP;
        end
      end
    endcase
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   ({r_pc, rom_inst}),
    .dout  (w_head),
    .count (w_count)
  );

  assign rom_addr  = r_pc;
  assign out_valid = (w_count != '0);
  assign out_pc    = w_head[2*XLEN-1:XLEN];
  assign out_inst  = w_head[XLEN-1:0];
  assign halt      = (r_state == S_HALT);

endmodule
